// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the load/store unit between the MEM stage and data_memory.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } mau_state_t;

  // Big-endian lane offsets: offset 0 is the most significant byte of the word.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  function automatic logic is_store(mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'd0;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store merge into a word and load extract with sign/zero extension.
module mem_lane_align
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [1:0]       offset,
  input  logic [WIDTH-1:0] word,
  input  logic [15:0]      store_half,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] load_data
);

  mem_op_t     op_e;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op_e = mem_op_t'(op);

  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = offset[1] ? word[15:0] : word[31:16];
    merged    = word;
    load_data = word;

    case (offset)
      OFF_B0:  byte_sel = word[31:24];
      OFF_B1:  byte_sel = word[23:16];
      OFF_B2:  byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase

    case (op_e)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase

    // Only the addressed lane(s) change; everything else comes from the captured word.
    case (op_e)
      OP_SB: begin
        case (offset)
          OFF_B0:  merged[31:24] = store_half[7:0];
          OFF_B1:  merged[23:16] = store_half[7:0];
          OFF_B2:  merged[15:8]  = store_half[7:0];
          default: merged[7:0]   = store_half[7:0];
        endcase
      end
      OP_SH: begin
        if (offset[1]) merged[15:0]  = store_half;
        else           merged[31:16] = store_half;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle sized load/store unit in front of a word-only data memory.
// Handshake: Req is sampled only while Busy is low; once accepted, Busy stays high
// until the cycle after the one-cycle Done pulse, and Req during Busy is ignored.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Req,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Address,
  input  logic [WIDTH-1:0] StoreData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] LoadData,
  output logic             AddrError,
  output logic [WIDTH-1:0] MemAddress,
  output logic [WIDTH-1:0] MemWriteData,
  output logic             MemWriteEnable,
  input  logic [WIDTH-1:0] MemReadData,
  output logic [1:0]       dbg_state
);

  mau_state_t       state_q, state_d;
  mem_op_t          op_q;
  mem_op_t          req_op;
  logic [1:0]       off_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] sdata_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] load_q;
  logic             err_q;
  logic             misaligned;
  logic             accept;
  logic [WIDTH-1:0] align_word;
  logic [WIDTH-1:0] merged_word;
  logic [WIDTH-1:0] load_word;

  assign req_op     = mem_op_t'(Op);
  assign misaligned = is_misaligned(req_op, Address[1:0]);
  assign accept     = (state_q == ST_IDLE) && Req && !misaligned;

  // Loads extract straight from the memory read in ACCESS; merges work on the captured word.
  assign align_word = (state_q == ST_ACCESS) ? MemReadData : word_q;

  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .op         (op_q),
    .offset     (off_q),
    .word       (align_word),
    .store_half (sdata_q[15:0]),
    .merged     (merged_word),
    .load_data  (load_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    MemWriteEnable = 1'b0;
    MemWriteData   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (op_q == OP_SB || op_q == OP_SH) state_d = ST_MERGE;
        else                                state_d = ST_RESP;
        if (op_q == OP_SW) begin
          MemWriteEnable = 1'b1;
          MemWriteData   = sdata_q;
        end
      end
      ST_MERGE: begin
        state_d        = ST_RESP;
        MemWriteEnable = 1'b1;
        MemWriteData   = merged_word;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q    <= OP_LB;
      off_q   <= 2'd0;
      addr_q  <= '0;
      sdata_q <= '0;
      word_q  <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && Req && misaligned;
      if (accept) begin
        op_q    <= req_op;
        off_q   <= Address[1:0];
        addr_q  <= {Address[WIDTH-1:2], 2'b00};
        sdata_q <= StoreData;
      end
      if (state_q == ST_ACCESS) begin
        word_q <= MemReadData;
        if (!is_store(op_q)) load_q <= load_word;
      end
    end
  end

  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_RESP);
  assign AddrError  = err_q;
  assign LoadData   = load_q;
  assign MemAddress = addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory, per-cycle output expectations, directed ops.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadData;
  logic        AddrError;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic [31:0] MemReadData;
  logic [1:0]  dbg_state;

  mem_access_unit #(.WIDTH(32)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .Req            (Req),
    .Op             (Op),
    .Address        (Address),
    .StoreData      (StoreData),
    .Busy           (Busy),
    .Done           (Done),
    .LoadData       (LoadData),
    .AddrError      (AddrError),
    .MemAddress     (MemAddress),
    .MemWriteData   (MemWriteData),
    .MemWriteEnable (MemWriteEnable),
    .MemReadData    (MemReadData),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / data memory ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [31:0] mem [0:15];
  assign MemReadData = mem[MemAddress[5:2]];
  always @(posedge CLK) if (MemWriteEnable) mem[MemAddress[5:2]] <= MemWriteData;

  // ---------------- reference model and scoreboard ----------------
  localparam int NCYC = 1024;
  logic [7:0]  ref_mem [0:63];
  logic        exp_busy [0:NCYC-1];
  logic        exp_done [0:NCYC-1];
  logic        exp_err  [0:NCYC-1];
  logic        exp_we   [0:NCYC-1];
  logic [31:0] exp_wd   [0:NCYC-1];
  logic        exp_ma_v [0:NCYC-1];
  logic [31:0] exp_ma   [0:NCYC-1];
  logic        exp_ld_v [0:NCYC-1];
  logic [31:0] exp_ld   [0:NCYC-1];
  logic [31:0] model_ld;
  int          free_cyc;
  bit          chk_en;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_mem[wa], ref_mem[wa+1], ref_mem[wa+2], ref_mem[wa+3]};
  endfunction

  // Drives a request now and records what the unit must do once it accepts it.
  task automatic present(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         output int a);
    int   ba;
    int   wa;
    int   lat;
    bit   mis;
    bit   st;
    logic [31:0] v;
    Req = 1'b1; Op = op; Address = addr; StoreData = sd;
    a   = (cyc > free_cyc) ? cyc : free_cyc;
    ba  = int'(addr[5:0]);
    wa  = ba & ~3;
    mis = ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]) ||
          ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00);
    if (mis) begin
      exp_err[a+1] = 1'b1;
      free_cyc     = a + 1;
      return;
    end
    st  = (op == OP_SB || op == OP_SH || op == OP_SW);
    lat = (op == OP_SB || op == OP_SH) ? 3 : 2;
    for (int k = 1; k <= lat; k++) exp_busy[a+k] = 1'b1;
    exp_done[a+lat] = 1'b1;
    exp_ma_v[a+1]   = 1'b1;
    exp_ma[a+1]     = {addr[31:2], 2'b00};
    v = 32'h0;
    case (op)
      OP_LB:  v = {{24{ref_mem[ba][7]}}, ref_mem[ba]};
      OP_LBU: v = {24'h0, ref_mem[ba]};
      OP_LH:  v = {{16{ref_mem[ba][7]}}, ref_mem[ba], ref_mem[ba+1]};
      OP_LHU: v = {16'h0, ref_mem[ba], ref_mem[ba+1]};
      OP_LW:  v = ref_word(wa);
      OP_SB:  ref_mem[ba] = sd[7:0];
      OP_SH:  begin ref_mem[ba] = sd[15:8]; ref_mem[ba+1] = sd[7:0]; end
      default: begin
        ref_mem[wa] = sd[31:24]; ref_mem[wa+1] = sd[23:16];
        ref_mem[wa+2] = sd[15:8]; ref_mem[wa+3] = sd[7:0];
      end
    endcase
    if (st) begin
      exp_we[a+lat-1] = 1'b1;
      exp_wd[a+lat-1] = ref_word(wa);
    end else begin
      exp_ld_v[a+lat] = 1'b1;
      exp_ld[a+lat]   = v;
    end
    free_cyc = a + lat + 1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
    int a;
    present(op, addr, sd, a);
    wait_until(a + 1);
    Req = 1'b0;
    wait_until(free_cyc);
  endtask

  // Per-cycle comparison of every visible output against the model's schedule.
  always @(negedge CLK) begin
    if (chk_en && cyc < NCYC) begin
      if (exp_ld_v[cyc]) model_ld = exp_ld[cyc];
      check("busy", {31'h0, Busy}, {31'h0, exp_busy[cyc]});
      check("done", {31'h0, Done}, {31'h0, exp_done[cyc]});
      check("addr_error", {31'h0, AddrError}, {31'h0, exp_err[cyc]});
      check("mem_we", {31'h0, MemWriteEnable}, {31'h0, exp_we[cyc]});
      if (exp_we[cyc]) check("mem_wdata", MemWriteData, exp_wd[cyc]);
      if (exp_ma_v[cyc]) check("mem_addr", MemAddress, exp_ma[cyc]);
      check("load_data", LoadData, model_ld);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] init_w [0:15];
    int a1;
    int a2;
    int ar;
    init_w[0] = 32'h8899AABB; init_w[1] = 32'h11223344;
    init_w[2] = 32'h55667788; init_w[3] = 32'h99AABBCC;
    for (int i = 4; i < 16; i++) init_w[i] = 32'h01010101 * i;
    for (int i = 0; i < 16; i++) begin
      mem[i] = init_w[i];
      ref_mem[4*i]   = init_w[i][31:24];
      ref_mem[4*i+1] = init_w[i][23:16];
      ref_mem[4*i+2] = init_w[i][15:8];
      ref_mem[4*i+3] = init_w[i][7:0];
    end
    for (int i = 0; i < NCYC; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_err[i] = 0; exp_we[i] = 0; exp_wd[i] = 0;
      exp_ma_v[i] = 0; exp_ma[i] = 0; exp_ld_v[i] = 0; exp_ld[i] = 0;
    end
    model_ld = 32'h0; free_cyc = 0; chk_en = 0;
    RST_N = 1'b0; Req = 1'b0; Op = 3'd0; Address = 32'h0; StoreData = 32'h0;

    #1;
    check("rst_busy", {31'h0, Busy}, 32'h0);
    check("rst_done", {31'h0, Done}, 32'h0);
    check("rst_err", {31'h0, AddrError}, 32'h0);
    check("rst_ldata", LoadData, 32'h0);
    check("rst_maddr", MemAddress, 32'h0);
    check("rst_wdata", MemWriteData, 32'h0);
    check("rst_we", {31'h0, MemWriteEnable}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);

    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    free_cyc = cyc;
    chk_en = 1;

    issue(OP_LB, 32'h1, 32'h0);         check("lb_lit", LoadData, 32'hFFFFFF99);
    issue(OP_LBU, 32'h1, 32'h0);        check("lbu_lit", LoadData, 32'h00000099);
    issue(OP_LH, 32'h2, 32'h0);         check("lh_lit", LoadData, 32'hFFFFAABB);
    issue(OP_LHU, 32'h2, 32'h0);        check("lhu_lit", LoadData, 32'h0000AABB);
    issue(OP_LW, 32'h0, 32'h0);         check("lw_lit", LoadData, 32'h8899AABB);
    issue(OP_SB, 32'h6, 32'h123456CC);  check("sb_mem_lit", mem[1], 32'h1122CC44);
    check("sb_ldata_held", LoadData, 32'h8899AABB);
    issue(OP_LW, 32'h4, 32'h0);         check("sb_readback_lit", LoadData, 32'h1122CC44);

    issue(OP_SH, 32'h3, 32'hFFFF);
    issue(OP_LW, 32'h2, 32'h0);         check("misaligned_ldata_held", LoadData, 32'h1122CC44);
    check("misaligned_mem_lit", mem[0], 32'h8899AABB);

    issue(OP_SH, 32'h8, 32'hDEADBEEF);  check("sh_mem_lit", mem[2], 32'hBEEF7788);
    issue(OP_LH, 32'h8, 32'h0);         check("sh_readback_lit", LoadData, 32'hFFFFBEEF);
    issue(OP_SW, 32'hC, 32'hCAFEF00D);  check("sw_mem_lit", mem[3], 32'hCAFEF00D);
    issue(OP_LB, 32'hF, 32'h0);         check("lb_pos_lit", LoadData, 32'h0000000D);
    issue(OP_LBU, 32'hC, 32'h0);        check("lbu_hi_lit", LoadData, 32'h000000CA);
    issue(OP_LHU, 32'hE, 32'h0);        check("lhu_lo_lit", LoadData, 32'h0000F00D);
    issue(OP_SB, 32'h13, 32'h5A);
    issue(OP_LW, 32'h10, 32'h0);        check("sb_off3_lit", LoadData, 32'h0404045A);

    // Request held through Busy with a different operation behind it.
    present(OP_LW, 32'h4, 32'h0, a1);
    @(negedge CLK);
    present(OP_SB, 32'h4, 32'h000000AB, a2);
    check("held_accept_gap", a2 - a1, 32'd3);
    wait_until(a2 + 1);
    Req = 1'b0;
    wait_until(free_cyc);
    check("held_first_lit", LoadData, 32'h1122CC44);
    issue(OP_LW, 32'h4, 32'h0);         check("held_second_lit", LoadData, 32'hAB22CC44);

    // Reset asserted while an SB sits in MERGE.
    chk_en = 0;
    ar = cyc;
    Req = 1'b1; Op = OP_SB; Address = 32'h0; StoreData = 32'h11;
    wait_until(ar + 1);
    Req = 1'b0;
    wait_until(ar + 2);
    check("pre_rst_we", {31'h0, MemWriteEnable}, 32'h1);
    check("pre_rst_state", {30'h0, dbg_state}, 32'h2);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_we", {31'h0, MemWriteEnable}, 32'h0);
    check("mid_rst_busy", {31'h0, Busy}, 32'h0);
    check("mid_rst_done", {31'h0, Done}, 32'h0);
    check("mid_rst_ldata", LoadData, 32'h0);
    check("mid_rst_maddr", MemAddress, 32'h0);
    check("mid_rst_wdata", MemWriteData, 32'h0);
    @(negedge CLK);
    check("mid_rst_mem_lit", mem[0], 32'h8899AABB);
    RST_N = 1'b1;
    @(negedge CLK);
    model_ld = 32'h0;
    free_cyc = cyc;
    chk_en = 1;
    issue(OP_LW, 32'h0, 32'h0);         check("post_rst_lw_lit", LoadData, 32'h8899AABB);

    chk_en = 0;
    for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_word(4*i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
